// File: rtl/shake256_arbiter_ctrl.sv
// Round-robin front end sharing one SHAKE256 core between two requesters:
// grants, latches the request, restarts the core and returns hash or error.
module shake256_arbiter_ctrl #(
    parameter int RATE       = 1088,
    parameter int LEN_W      = 11,
    parameter int MAX_LEN    = 1087,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [RATE-1:0]  req0_message,
    input  logic [LEN_W-1:0] req0_length,
    input  logic [RATE-1:0]  req1_message,
    input  logic [LEN_W-1:0] req1_length,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_error,
    output logic [RATE-1:0]  rsp_hash,
    output logic             busy,
    output logic             core_reset,
    output logic [RATE-1:0]  core_message,
    output logic [LEN_W-1:0] core_length,
    input  logic             core_squeezed,
    input  logic [RATE-1:0]  core_hash
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RESP
    } state_t;

    state_t             state, state_d;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic               rr_ptr, rr_ptr_d;
    logic               rsp_id_d, rsp_error_d;
    logic [RATE-1:0]    rsp_hash_d, core_message_d;
    logic [LEN_W-1:0]   core_length_d;
    logic [1:0]         ready_d;

    logic               grant_valid;
    logic               grant_id;
    logic [RATE-1:0]    grant_message;
    logic [LEN_W-1:0]   grant_length;

    always_comb begin
        grant_valid   = |req_valid;
        grant_id      = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        grant_message = grant_id ? req1_message : req0_message;
        grant_length  = grant_id ? req1_length  : req0_length;
    end

    always_comb begin
        state_d        = state;
        rst_cnt_d      = rst_cnt;
        timer_d        = timer;
        rr_ptr_d       = rr_ptr;
        rsp_id_d       = rsp_id;
        rsp_error_d    = rsp_error;
        rsp_hash_d     = rsp_hash;
        core_message_d = core_message;
        core_length_d  = core_length;
        ready_d        = '0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    ready_d[grant_id] = 1'b1;
                    rr_ptr_d          = ~grant_id;
                    rsp_id_d          = grant_id;
                    core_message_d    = grant_message;
                    core_length_d     = grant_length;
                    rst_cnt_d         = '0;
                    // Over-length requests are answered directly; the core is left untouched.
                    if (int'(grant_length) > MAX_LEN) begin
                        rsp_error_d = 1'b1;
                        rsp_hash_d  = '0;
                        state_d     = RESP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            RUN: begin
                timer_d = timer + 1'b1;
                // timer==0 marks the first RUN cycle, where squeezed may still be stale.
                if (timer != '0 && core_squeezed) begin
                    rsp_hash_d  = core_hash;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    rsp_hash_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            timer        <= '0;
            rr_ptr       <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_hash     <= '0;
            core_message <= '0;
            core_length  <= '0;
        end else begin
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            timer        <= timer_d;
            rr_ptr       <= rr_ptr_d;
            rsp_id       <= rsp_id_d;
            rsp_error    <= rsp_error_d;
            rsp_hash     <= rsp_hash_d;
            core_message <= core_message_d;
            core_length  <= core_length_d;
        end
    end

    assign req_ready  = reset ? 2'b00 : ready_d;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign core_reset = reset | (state == START);

endmodule

// File: tb/tb_shake256_arbiter_ctrl.sv
// Bench for shake256_arbiter_ctrl: directed vector table, hand sequences and
// random transactions checked against a transaction-level arbitration/latency model.
module tb_shake256_arbiter_ctrl;

    localparam int RATE       = 1088;
    localparam int LEN_W      = 11;
    localparam int MAX_LEN    = 1087;
    localparam int RST_CYCLES = 2;
    localparam int TIMEOUT    = 255;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [RATE-1:0]  req0_message, req1_message;
    logic [LEN_W-1:0] req0_length, req1_length;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_error;
    logic [RATE-1:0]  rsp_hash;
    logic             busy, core_reset;
    logic [RATE-1:0]  core_message, core_hash;
    logic [LEN_W-1:0] core_length;
    logic             core_squeezed;

    always #5 clock = ~clock;

    shake256_arbiter_ctrl #(
        .RATE(RATE), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_message(req0_message), .req0_length(req0_length),
        .req1_message(req1_message), .req1_length(req1_length),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_error(rsp_error), .rsp_hash(rsp_hash), .busy(busy),
        .core_reset(core_reset), .core_message(core_message), .core_length(core_length),
        .core_squeezed(core_squeezed), .core_hash(core_hash)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [RATE-1:0] hash_of(input logic [RATE-1:0] m, input logic [LEN_W-1:0] l);
        logic [RATE-1:0] r;
        r = {m[RATE-8:0], m[RATE-1:RATE-7]};
        return ~r ^ {{(RATE-LEN_W){1'b0}}, l};
    endfunction

    function automatic logic [RATE-1:0] rand_msg();
        logic [RATE-1:0] v;
        for (int i = 0; i < RATE / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Core model: squeezed rises lat+1 cycles after its reset is released.
    int   cm_lat   = 0;
    bit   cm_stale = 1'b0;
    int   cm_cnt   = 0;
    logic cm_sq    = 1'b0;
    always @(posedge clock) begin
        if (core_reset) begin
            cm_cnt <= 0;
            cm_sq  <= cm_stale;
        end else begin
            cm_cnt <= cm_cnt + 1;
            cm_sq  <= (cm_cnt + 1 >= cm_lat);
        end
    end
    assign core_squeezed = cm_sq;
    assign core_hash     = hash_of(core_message, core_length);

    // Reference: RUN cycle in which the result is taken, counted from 1.
    function automatic int done_cycle(input int lat);
        int d;
        d = (lat + 1 < 2) ? 2 : lat + 1;
        return d;
    endfunction

    function automatic bit exp_error(input int len, input int lat);
        return (len > MAX_LEN) || (done_cycle(lat) > TIMEOUT);
    endfunction

    function automatic int exp_cycles(input int len, input int lat);
        int d;
        if (len > MAX_LEN) return 1;
        d = done_cycle(lat);
        if (d > TIMEOUT) d = TIMEOUT;
        return 1 + RST_CYCLES + d;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [RATE-1:0] act, input logic [RATE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got low128 %h expected low128 %h", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic run_txn(input logic [1:0] mask, input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                           input int lat, input bit stale, input int delay,
                           input int exp_g, input bit exp_err, input int exp_n);
        logic [RATE-1:0] m0, m1, exp_hash;
        int  n;
        bit  seen;
        bit  overlen;
        m0 = rand_msg();
        m1 = rand_msg();
        req0_message = m0; req0_length = l0;
        req1_message = m1; req1_length = l1;
        cm_lat = lat; cm_stale = stale;
        req_valid = mask;
        overlen  = int'(exp_g == 1 ? l1 : l0) > MAX_LEN;
        exp_hash = exp_err ? '0 : (exp_g == 1 ? hash_of(m1, l1) : hash_of(m0, l0));
        #1;
        check("req_ready_grant", req_ready, (exp_g == 1) ? 2 : 1);
        @(posedge clock);
        #1;
        req_valid[exp_g] = 1'b0;
        if (exp_g == 1) req1_message = rand_msg(); else req0_message = rand_msg();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clock);
            n++;
            if (n <= RST_CYCLES + 1) check("core_reset_seq", core_reset, (!overlen && n <= RST_CYCLES));
            check("req_ready_busy", req_ready, 0);
            seen = rsp_valid;
        end
        check("rsp_latency", n, exp_n);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, exp_g);
        check("rsp_error", rsp_error, exp_err);
        check_w("rsp_hash", rsp_hash, exp_hash);
        check("busy_resp", busy, 1);
        for (int d = 0; d < delay; d++) begin
            @(negedge clock);
            check("hold_valid", rsp_valid, 1);
            check("hold_id", rsp_id, exp_g);
            check("hold_error", rsp_error, exp_err);
            check_w("hold_hash", rsp_hash, exp_hash);
            check("hold_no_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("busy_after_hs", busy, 0);
    endtask

    typedef struct {
        logic [1:0] mask;
        int         l0, l1, lat;
        bit         stale;
        int         delay;
        int         exp_g;
        bit         exp_err;
        int         exp_n;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int rr, g, glen, lat, delay;
        logic [1:0] mask;
        logic [LEN_W-1:0] l0, l1;

        tbl[0]  = '{2'b11,    0,    0,   0, 1'b0,  0, 0, 1'b0,   5};
        tbl[1]  = '{2'b11,  100,  200,   3, 1'b0,  0, 1, 1'b0,   7};
        tbl[2]  = '{2'b11,    5,    6,   1, 1'b0,  0, 0, 1'b0,   5};
        tbl[3]  = '{2'b11,    7,    8,   2, 1'b0, 10, 1, 1'b0,   6};
        tbl[4]  = '{2'b01,    0,    0,   0, 1'b0,  0, 0, 1'b0,   5};
        tbl[5]  = '{2'b10,    0, 1100,   0, 1'b0,  0, 1, 1'b1,   1};
        tbl[6]  = '{2'b01, 1087,    0, 254, 1'b0,  0, 0, 1'b0, 258};
        tbl[7]  = '{2'b10,    0, 1088,   0, 1'b0,  0, 1, 1'b1,   1};
        tbl[8]  = '{2'b01,    0,    0, 255, 1'b0,  0, 0, 1'b1, 258};
        tbl[9]  = '{2'b10,    0,    9,   1, 1'b0,  0, 1, 1'b0,   5};
        tbl[10] = '{2'b01,    3,    0,  10, 1'b1,  0, 0, 1'b0,  14};
        tbl[11] = '{2'b11,   50, 2047,   0, 1'b0,  2, 1, 1'b1,   1};

        reset = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req0_message = '0; req1_message = '0;
        req0_length = '0;  req1_length = '0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_error", rsp_error, 0);
        check_w("rst_rsp_hash", rsp_hash, '0);
        check("rst_busy", busy, 0);
        check_w("rst_core_message", core_message, '0);
        check("rst_core_length", core_length, 0);
        check("rst_core_reset", core_reset, 1);
        req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clock);
        check("idle_core_reset", core_reset, 0);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].mask, LEN_W'(tbl[i].l0), LEN_W'(tbl[i].l1), tbl[i].lat, tbl[i].stale,
                    tbl[i].delay, tbl[i].exp_g, tbl[i].exp_err, tbl[i].exp_n);
        end

        // Reset in the middle of RUN drops the request and re-prefers requester 0.
        cm_lat = 100000; cm_stale = 1'b0;
        req0_length = 20;
        req_valid = 2'b01;
        #1;
        check("midrst_grant", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (5) @(negedge clock);
        check("midrst_busy_run", busy, 1);
        check("midrst_core_reset_run", core_reset, 0);
        reset = 1'b1;
        req_valid = 2'b10;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_req_ready", req_ready, 0);
        reset = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clock);
        check("midrst_no_rsp", rsp_valid, 0);
        check("midrst_idle", busy, 0);
        check("midrst_core_reset_off", core_reset, 0);

        rr = 0;
        for (int k = 0; k < 25; k++) begin
            mask  = (k == 0) ? 2'b11 : 2'($urandom_range(1, 3));
            l0    = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(1088, 2047)) : LEN_W'($urandom_range(0, 1087));
            l1    = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(1088, 2047)) : LEN_W'($urandom_range(0, 1087));
            lat   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(0, 20));
            delay = int'($urandom_range(0, 3));
            g     = (mask == 2'b11) ? rr : ((mask == 2'b10) ? 1 : 0);
            rr    = 1 - g;
            glen  = (g == 1) ? int'(l1) : int'(l0);
            run_txn(mask, l0, l1, lat, 1'b0, delay, g, exp_error(glen, lat), exp_cycles(glen, lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
